// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl: round-robin arbiter and block sequencer that streams
// data blocks from one of two requesters through a single ChaCha core,
// keeping exactly one block in flight.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no job; grant a pending request in the same cycle
//   LOAD  | wait for an input block and a free core, then pulse init/next
//   WAIT  | core computing; capture its result on core_valid
//   HOLD  | present the result until out_ready, then advance ctr/remaining
module chacha_stream_ctrl #(
    parameter int NBLK_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          cmd_valid,
    output logic [1:0]          cmd_ready,
    input  logic [511:0]        cmd_key,
    input  logic [127:0]        cmd_iv,
    input  logic [127:0]        cmd_ctr,
    input  logic [2*NBLK_W-1:0] cmd_nblk,
    output logic                grant_id,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [511:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [511:0]        out_data,
    output logic                out_id,
    output logic                out_last,
    output logic [63:0]         out_ctr,
    output logic                core_init,
    output logic                core_next,
    output logic [255:0]        core_key,
    output logic [63:0]         core_ctr,
    output logic [63:0]         core_iv,
    output logic [511:0]        core_data_in,
    input  logic                core_ready,
    input  logic                core_valid,
    input  logic [511:0]        core_data_out
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_t;

    // Remaining-block counter is one bit wider so a zero count can mean 2^NBLK_W.
    localparam logic [NBLK_W:0] REM_ONE  = 1;
    localparam logic [NBLK_W:0] REM_FULL = {1'b1, {NBLK_W{1'b0}}};

    state_t             state, state_nx;
    logic               rr_last;
    logic               win;
    logic               grant, in_fire, res_cap, out_fire;
    logic [NBLK_W-1:0]  nblk_sel;
    logic [255:0]       key_r;
    logic [63:0]        iv_r, ctr_r;
    logic [NBLK_W:0]    rem_r;
    logic               first_r;
    logic [511:0]       data_r;

    // Round-robin pick: on contention serve the requester not granted last.
    always_comb begin
        if (cmd_valid == 2'b11) win = ~rr_last;
        else                    win = cmd_valid[1];
        nblk_sel = win ? cmd_nblk[2*NBLK_W-1:NBLK_W] : cmd_nblk[NBLK_W-1:0];
    end

    // Next state plus handshake and core-pulse decode.
    always_comb begin
        state_nx  = state;
        cmd_ready = 2'b00;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        core_init = 1'b0;
        core_next = 1'b0;
        busy      = 1'b1;
        grant     = 1'b0;
        in_fire   = 1'b0;
        res_cap   = 1'b0;
        out_fire  = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (|cmd_valid) begin
                    grant     = 1'b1;
                    cmd_ready = win ? 2'b10 : 2'b01;
                    state_nx  = LOAD;
                end
            end
            LOAD: begin
                in_ready = core_ready;
                if (in_valid && core_ready) begin
                    in_fire   = 1'b1;
                    core_init = first_r;
                    core_next = ~first_r;
                    state_nx  = WAIT;
                end
            end
            WAIT: begin
                if (core_valid) begin
                    res_cap  = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    out_fire = 1'b1;
                    state_nx = (rem_r == REM_ONE) ? IDLE : LOAD;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The block is passed straight through during the pulse cycle; the
    // captured copy keeps the operand stable while the core works.
    assign core_key     = key_r;
    assign core_iv      = iv_r;
    assign core_ctr     = ctr_r;
    assign core_data_in = (state == LOAD) ? in_data : data_r;

    // State, job context and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            grant_id <= 1'b0;
            key_r    <= '0;
            iv_r     <= '0;
            ctr_r    <= '0;
            rem_r    <= '0;
            first_r  <= 1'b0;
            data_r   <= '0;
            out_data <= '0;
            out_ctr  <= '0;
            out_last <= 1'b0;
            out_id   <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                rr_last  <= win;
                grant_id <= win;
                key_r    <= win ? cmd_key[511:256] : cmd_key[255:0];
                iv_r     <= win ? cmd_iv[127:64]   : cmd_iv[63:0];
                ctr_r    <= win ? cmd_ctr[127:64]  : cmd_ctr[63:0];
                rem_r    <= (nblk_sel == '0) ? REM_FULL : {1'b0, nblk_sel};
                first_r  <= 1'b1;
            end
            if (in_fire) begin
                data_r  <= in_data;
                first_r <= 1'b0;
            end
            if (res_cap) begin
                out_data <= core_data_out;
                out_ctr  <= ctr_r;
                out_last <= (rem_r == REM_ONE);
                out_id   <= grant_id;
            end
            if (out_fire) begin
                ctr_r <= ctr_r + 64'd1;
                rem_r <= rem_r - REM_ONE;
            end
        end
    end
endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Bench for chacha_stream_ctrl: job-level reference model, a toy cipher core,
// randomized traffic and a few directed scenarios with literal expectations.
module tb_chacha_stream_ctrl;
    localparam int NBLK_W = 8;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [1:0]          cmd_valid;
    logic [1:0]          cmd_ready;
    logic [511:0]        cmd_key;
    logic [127:0]        cmd_iv;
    logic [127:0]        cmd_ctr;
    logic [2*NBLK_W-1:0] cmd_nblk;
    logic                grant_id, busy;
    logic                in_valid, in_ready;
    logic [511:0]        in_data;
    logic                out_valid, out_ready;
    logic [511:0]        out_data;
    logic                out_id, out_last;
    logic [63:0]         out_ctr;
    logic                core_init, core_next;
    logic [255:0]        core_key;
    logic [63:0]         core_ctr, core_iv;
    logic [511:0]        core_data_in;
    logic                core_ready, core_valid;
    logic [511:0]        core_data_out;

    always #5 clk = ~clk;

    chacha_stream_ctrl #(.NBLK_W(NBLK_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
        .cmd_iv(cmd_iv), .cmd_ctr(cmd_ctr), .cmd_nblk(cmd_nblk),
        .grant_id(grant_id), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .out_last(out_last), .out_ctr(out_ctr),
        .core_init(core_init), .core_next(core_next), .core_key(core_key),
        .core_ctr(core_ctr), .core_iv(core_iv), .core_data_in(core_data_in),
        .core_ready(core_ready), .core_valid(core_valid), .core_data_out(core_data_out)
    );

    typedef struct {
        logic [255:0]      key;
        logic [63:0]       iv;
        logic [63:0]       ctr;
        logic [NBLK_W-1:0] nblk;
    } job_t;

    job_t pend0[$], pend1[$];

    int checks = 0;
    int errors = 0;

    // stimulus modes
    bit in_mode = 1'b1, crdy_mode = 1'b1;
    int ordy_mode = 1;
    int lat_min = 0, lat_max = 3;

    // toy core state
    bit core_pulse = 1'b0, core_busy = 1'b0;
    int core_cnt = 0;

    // job-level reference model
    bit           m_active = 1'b0, m_first = 1'b0, m_id = 1'b0, m_last_gnt = 1'b1;
    int           m_phase = 0;   // 0 awaiting block, 1 core computing, 2 result offered
    int           m_rem = 0;
    logic [255:0] m_key;
    logic [63:0]  m_iv, m_ctr;
    logic [511:0] m_blk;

    // observations of the DUT at output handshakes
    logic [63:0] d_ctr[$];
    bit          d_last[$];
    bit          d_id[$];
    int          n_init = 0, n_next = 0;

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [511:0] r512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Stand-in keystream: any fixed function of key/iv/ctr exposes operand errors.
    function automatic logic [511:0] ks(input logic [255:0] k, input logic [63:0] iv,
                                        input logic [63:0] c);
        logic [63:0] m;
        m = (c * 64'h9E37_79B9_7F4A_7C15) ^ iv;
        return {k, iv, c, ~k[127:0]} ^ {8{m}};
    endfunction

    function automatic bit rr_pick(input logic [1:0] v, input bit last);
        return (v == 2'b11) ? !last : v[1];
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_job(input bit r, input logic [63:0] c, input logic [NBLK_W-1:0] nb);
        job_t j;
        j.key  = {r64(), r64(), r64(), r64()};
        j.iv   = r64();
        j.ctr  = c;
        j.nblk = nb;
        if (r) pend1.push_back(j);
        else   pend0.push_back(j);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_active || pend0.size() != 0 || pend1.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles", n);
        end
    endtask

    task automatic clear_obs();
        d_ctr.delete();
        d_last.delete();
        d_id.delete();
        n_init = 0;
        n_next = 0;
    endtask

    // Reference model advance and DUT observation at each rising edge.
    always @(posedge clk) begin
        core_pulse = reset_n && (core_init || core_next);
        if (!reset_n) begin
            m_active   = 1'b0;
            m_last_gnt = 1'b1;
            m_phase    = 0;
        end else begin
            if (core_init) n_init++;
            if (core_next) n_next++;
            if (out_valid && out_ready) begin
                d_ctr.push_back(out_ctr);
                d_last.push_back(out_last);
                d_id.push_back(out_id);
            end
            if (!m_active) begin
                if (cmd_valid != 2'b00) begin
                    job_t j;
                    bit   w;
                    w = rr_pick(cmd_valid, m_last_gnt);
                    if (w) j = pend1.pop_front();
                    else   j = pend0.pop_front();
                    m_key      = j.key;
                    m_iv       = j.iv;
                    m_ctr      = j.ctr;
                    m_rem      = (j.nblk == 0) ? (1 << NBLK_W) : int'(j.nblk);
                    m_id       = w;
                    m_last_gnt = w;
                    m_first    = 1'b1;
                    m_phase    = 0;
                    m_active   = 1'b1;
                end
            end else begin
                case (m_phase)
                    0: if (in_valid && core_ready) begin
                        m_blk   = in_data;
                        m_first = 1'b0;
                        m_phase = 1;
                    end
                    1: if (core_valid) m_phase = 2;
                    default: if (out_ready) begin
                        m_ctr = m_ctr + 64'd1;
                        m_rem--;
                        if (m_rem == 0) m_active = 1'b0;
                        else            m_phase = 0;
                    end
                endcase
            end
        end
    end

    // Input drivers and toy cipher core, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        cmd_valid = {pend1.size() != 0, pend0.size() != 0};
        cmd_key = '0; cmd_iv = '0; cmd_ctr = '0; cmd_nblk = '0;
        if (pend0.size() != 0) begin
            cmd_key[255:0]         = pend0[0].key;
            cmd_iv[63:0]           = pend0[0].iv;
            cmd_ctr[63:0]          = pend0[0].ctr;
            cmd_nblk[NBLK_W-1:0]   = pend0[0].nblk;
        end
        if (pend1.size() != 0) begin
            cmd_key[511:256]          = pend1[0].key;
            cmd_iv[127:64]            = pend1[0].iv;
            cmd_ctr[127:64]           = pend1[0].ctr;
            cmd_nblk[2*NBLK_W-1:NBLK_W] = pend1[0].nblk;
        end
        in_valid = in_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
        in_data  = r512();
        case (ordy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
        if (core_pulse) begin
            core_busy = 1'b1;
            core_cnt  = $urandom_range(lat_min, lat_max);
        end
        core_valid = 1'b0;
        if (core_busy) begin
            if (core_cnt == 0) begin
                core_valid    = 1'b1;
                core_data_out = core_data_in ^ ks(core_key, core_iv, core_ctr);
                core_busy     = 1'b0;
            end else begin
                core_cnt--;
            end
        end else if ($urandom_range(0, 15) == 0) begin
            core_valid    = 1'b1;
            core_data_out = r512();
        end
        core_ready = !core_busy && (crdy_mode || $urandom_range(0, 3) != 0);
    end

    // Cycle-by-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        bit         exp_pulse;
        if (!reset_n) begin
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_core_pulse", {core_init, core_next}, 0);
            chk("rst_grant_id", grant_id, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_ctr", out_ctr, 0);
            chk("rst_out_last_id", {out_last, out_id}, 0);
        end else begin
            exp_rdy = 2'b00;
            if (!m_active && cmd_valid != 2'b00)
                exp_rdy = rr_pick(cmd_valid, m_last_gnt) ? 2'b10 : 2'b01;
            exp_pulse = m_active && m_phase == 0 && in_valid && core_ready;
            chk("cmd_ready", cmd_ready, exp_rdy);
            chk("busy", busy, m_active);
            chk("in_ready", in_ready, m_active && m_phase == 0 && core_ready);
            chk("core_init", core_init, exp_pulse && m_first);
            chk("core_next", core_next, exp_pulse && !m_first);
            chk("out_valid", out_valid, m_active && m_phase == 2);
            if (m_active) chk("grant_id", grant_id, m_id);
            if (exp_pulse) begin
                chk("core_key", core_key, m_key);
                chk("core_iv", core_iv, m_iv);
                chk("core_ctr", core_ctr, m_ctr);
                chk("core_data_in", core_data_in, in_data);
            end
            if (m_active && m_phase == 2) begin
                chk("out_data", out_data, m_blk ^ ks(m_key, m_iv, m_ctr));
                chk("out_ctr", out_ctr, m_ctr);
                chk("out_last", out_last, m_rem == 1);
                chk("out_id", out_id, m_id);
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   stall_hit;
        int   n, lasts, n_ov;
        logic [511:0] held;

        cmd_valid = '0; cmd_key = '0; cmd_iv = '0; cmd_ctr = '0; cmd_nblk = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        core_ready = 1'b0; core_valid = 1'b0; core_data_out = '0;

        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);

        // Contention from reset, then a lone req0, then contention again.
        clear_obs();
        push_job(1'b0, r64(), 8'd1);
        push_job(1'b1, r64(), 8'd1);
        wait_idle(200);
        push_job(1'b0, r64(), 8'd1);
        wait_idle(200);
        push_job(1'b0, r64(), 8'd1);
        push_job(1'b1, r64(), 8'd1);
        wait_idle(200);
        chk("rr_count", d_id.size(), 5);
        if (d_id.size() == 5)
            chk("rr_order", {d_id[0], d_id[1], d_id[2], d_id[3], d_id[4]}, 5'b01010);

        // Three-block job from req0 starting at counter 5.
        clear_obs();
        push_job(1'b0, 64'd5, 8'd3);
        wait_idle(200);
        chk("j3_count", d_ctr.size(), 3);
        if (d_ctr.size() == 3) begin
            chk("j3_ctr0", d_ctr[0], 64'd5);
            chk("j3_ctr1", d_ctr[1], 64'd6);
            chk("j3_ctr2", d_ctr[2], 64'd7);
            chk("j3_last", {d_last[0], d_last[1], d_last[2]}, 3'b001);
            chk("j3_id", {d_id[0], d_id[1], d_id[2]}, 3'b000);
        end
        chk("j3_inits", n_init, 1);
        chk("j3_nexts", n_next, 2);

        // Counter wrap at 2^64-1.
        clear_obs();
        push_job(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'd2);
        wait_idle(200);
        chk("wrap_count", d_ctr.size(), 2);
        if (d_ctr.size() == 2) begin
            chk("wrap_ctr0", d_ctr[0], 64'hFFFF_FFFF_FFFF_FFFF);
            chk("wrap_ctr1", d_ctr[1], 64'd0);
        end

        // Output back-pressure for 10 cycles while a result is held.
        clear_obs();
        ordy_mode = 2;
        push_job(1'b1, r64(), 8'd2);
        n = 0;
        while (!(m_active && m_phase == 2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        stall_hit = (n < 200);
        chk("stall_reached", stall_hit, 1'b1);
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_data", out_data, held);
            chk("stall_pulse", {core_init, core_next}, 2'b00);
            chk("stall_in_ready", in_ready, 1'b0);
        end
        ordy_mode = 1;
        wait_idle(200);
        chk("stall_blocks", d_ctr.size(), 2);

        // nblk = 0 means 256 blocks.
        clear_obs();
        push_job(1'b0, r64(), 8'd0);
        wait_idle(6000);
        chk("full_count", d_ctr.size(), 256);
        lasts = 0;
        foreach (d_last[i]) if (d_last[i]) lasts++;
        chk("full_lasts", lasts, 1);
        if (d_last.size() == 256) chk("full_last_pos", d_last[255], 1'b1);

        // Randomized traffic with random back-pressure on every interface.
        in_mode = 1'b0; crdy_mode = 1'b0; ordy_mode = 0;
        for (int k = 0; k < 30; k++) begin
            logic [63:0] c;
            c = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : r64();
            push_job($urandom_range(0, 1), c, 8'($urandom_range(1, 5)));
            if ($urandom_range(0, 2) == 0) push_job($urandom_range(0, 1), r64(), 8'($urandom_range(1, 3)));
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        wait_idle(20000);

        // Reset while the core is computing; its late result must be ignored.
        in_mode = 1'b1; crdy_mode = 1'b1; ordy_mode = 1;
        lat_min = 4; lat_max = 6;
        push_job(1'b0, r64(), 8'd3);
        n = 0;
        while (!(m_active && m_phase == 1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wait_reached", n < 200, 1'b1);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        n_ov = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) n_ov++;
        end
        chk("post_reset_out_valid", n_ov, 0);
        chk("post_reset_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
